bcd_digit_source: RTL

// - Converts an unsigned binary value into packed BCD digits, one 4-bit digit per position.
// - Drives the `digit` inputs of a row of on-screen digit renderers (score, counters, timers).
// - Iterative shift-add-3 (double-dabble) engine with a load/done handshake.
// - Digit outputs stay stable between updates, so renderers never see a partial result mid-frame.

---
 rtl/bcd_digit_source.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bcd_digit_source.sv
// rtl/bcd_digit_source.sv - binary to packed BCD converter (double-dabble) with load/done handshake
// Optional leading-zero blanking enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_digit_source #(
   parameter int BIN_WIDTH  = 11,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    load,
   input  logic [BIN_WIDTH-1:0]    value_in,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    overflow,
   output logic [NUM_DIGITS-1:0]   blank_mask
);

   localparam int CNT_W = $clog2(BIN_WIDTH + 1);
   localparam int DIG_W = 4 * NUM_DIGITS;
   // One spare nibble keeps the accumulator exact even when the value saturates.
   localparam int ACC_W = 4 * (NUM_DIGITS + 1);
   localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS) - 64'd1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIN_WIDTH-1:0] bin_q, bin_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                ovf_pend_q, ovf_pend_d;
   logic [DIG_W-1:0]    digits_q, digits_d;
   logic                overflow_q, overflow_d;
   logic [NUM_DIGITS-1:0] blank_q, blank_d;
   logic                done_q, done_d;

   logic [ACC_W-1:0]    acc_adj;
   logic [NUM_DIGITS-1:0] blank_calc;

   always_comb begin
      acc_adj = acc_q;
      for (int k = 0; k < NUM_DIGITS + 1; k++) begin
         if (acc_q[4*k +: 4] >= 4'd5) begin
            acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic zero_run;

   always_comb begin
      blank_calc = '0;
      zero_run   = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run      = zero_run && (acc_q[4*k +: 4] == 4'd0);
         blank_calc[k] = zero_run;
      end
   end
`else
   assign blank_calc = '0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bin_d      = bin_q;
      acc_d      = acc_q;
      ovf_pend_d = ovf_pend_q;
      digits_d   = digits_q;
      overflow_d = overflow_q;
      blank_d    = blank_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               bin_d      = value_in;
               acc_d      = '0;
               cnt_d      = '0;
               ovf_pend_d = (64'(value_in) > MAX_VAL);
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            {acc_d, bin_d} = {acc_adj, bin_q} << 1;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // All published outputs change together, in the single done cycle.
            done_d     = 1'b1;
            overflow_d = ovf_pend_q;
            if (ovf_pend_q) begin
               digits_d = {NUM_DIGITS{4'h9}};
               blank_d  = '0;
            end else begin
               digits_d = acc_q[DIG_W-1:0];
               blank_d  = blank_calc;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bin_q      <= '0;
         acc_q      <= '0;
         ovf_pend_q <= 1'b0;
         digits_q   <= '0;
         overflow_q <= 1'b0;
         blank_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bin_q      <= bin_d;
         acc_q      <= acc_d;
         ovf_pend_q <= ovf_pend_d;
         digits_q   <= digits_d;
         overflow_q <= overflow_d;
         blank_q    <= blank_d;
         done_q     <= done_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign digits     = digits_q;
   assign overflow   = overflow_q;
   assign blank_mask = blank_q;

endmodule
